// File: rtl/shift_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_if : operand-2 bus between the register file, the barrel shifter and the ALU
// Revision : 1.0
// ----------------------------------------------------------------------------
interface shift_if;
  logic [2:0]  SHIFT_OP;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic        Carry_flag;
  logic [31:0] Shift_Out;
  logic        Shift_Carry_Out;

  modport master (
    output SHIFT_OP, Shift_Data, Shift_Num, Carry_flag,
    input  Shift_Out, Shift_Carry_Out
  );

  modport slave (
    input  SHIFT_OP, Shift_Data, Shift_Num, Carry_flag,
    output Shift_Out, Shift_Carry_Out
  );
endinterface
`default_nettype wire

// File: rtl/shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift    : combinational ARM barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out
// Revision : 1.0
// ----------------------------------------------------------------------------
module shift (
  input  logic   clk,
  input  logic   rst,
  shift_if.slave bus
);
  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  logic [31:0] d;
  logic [7:0]  n;
  logic [4:0]  sh;
  logic [1:0]  typ;
  logic        reg_amt;
  logic        cin;
  logic        sign;
  logic [31:0] fill;
  logic [31:0] lsl_v;
  logic [31:0] lsr_v;
  logic [31:0] asr_v;
  logic [31:0] ror_v;
  logic        lsl_c;
  logic        right_c;
  logic        n_small;
  logic        n_is_32;
  logic [31:0] out;
  logic        c;
  logic        unused_clk_rst;

  // The shifter is purely combinational; clk/rst exist only for interface uniformity.
  assign unused_clk_rst = clk ^ rst;

  assign d       = bus.Shift_Data;
  assign n       = bus.Shift_Num;
  assign sh      = n[4:0];
  assign typ     = bus.SHIFT_OP[2:1];
  assign reg_amt = bus.SHIFT_OP[0];
  assign cin     = bus.Carry_flag;
  assign sign    = d[31];
  assign fill    = {32{sign}};

  assign lsl_v   = d << sh;
  assign lsr_v   = d >> sh;
  assign asr_v   = $signed(d) >>> sh;
  assign ror_v   = (d >> sh) | (d << (5'd0 - sh));
  // Last bit shifted out: bit (32-sh) going left, bit (sh-1) going right.
  assign lsl_c   = d[5'd0 - sh];
  assign right_c = d[sh - 5'd1];
  assign n_small = (n[7:5] == 3'b000);
  assign n_is_32 = (n == 8'd32);

  always_comb begin
    out = d;
    c   = cin;
    if (!reg_amt) begin
      if (sh == 5'd0) begin
        // Immediate #0 encodes LSR/ASR #32 and RRX.
        case (typ)
          T_LSL: begin out = d;               c = cin;  end
          T_LSR: begin out = 32'd0;           c = sign; end
          T_ASR: begin out = fill;            c = sign; end
          T_ROR: begin out = {cin, d[31:1]};  c = d[0]; end
          default: begin out = d;             c = cin;  end
        endcase
      end else begin
        case (typ)
          T_LSL: begin out = lsl_v; c = lsl_c;   end
          T_LSR: begin out = lsr_v; c = right_c; end
          T_ASR: begin out = asr_v; c = right_c; end
          T_ROR: begin out = ror_v; c = right_c; end
          default: begin out = d;   c = cin;     end
        endcase
      end
    end else if (n != 8'd0) begin
      case (typ)
        T_LSL: begin
          if (n_small)      begin out = lsl_v; c = lsl_c; end
          else if (n_is_32) begin out = 32'd0; c = d[0];  end
          else              begin out = 32'd0; c = 1'b0;  end
        end
        T_LSR: begin
          if (n_small)      begin out = lsr_v; c = right_c; end
          else if (n_is_32) begin out = 32'd0; c = sign;    end
          else              begin out = 32'd0; c = 1'b0;    end
        end
        T_ASR: begin
          if (n_small) begin out = asr_v; c = right_c; end
          else         begin out = fill;  c = sign;    end
        end
        T_ROR: begin
          if (sh != 5'd0) begin out = ror_v; c = right_c; end
          else            begin out = d;     c = sign;    end
        end
        default: begin out = d; c = cin; end
      endcase
    end
  end

  assign bus.Shift_Out       = out;
  assign bus.Shift_Carry_Out = c;
endmodule
`default_nettype wire

// File: tb/tb_shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_shift : directed and random checks of the barrel shifter against a bit-serial model
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_shift;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  shift_if sif ();

  shift u_dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: shift one bit at a time, carry is the last bit moved out.
  function automatic logic [32:0] ref_model(input logic [2:0] op, input logic [31:0] d,
                                            input logic [7:0] num, input logic cin);
    int          amt;
    logic [31:0] v;
    logic        c;
    v = d;
    c = cin;
    if (op[0]) amt = int'(num);
    else begin
      amt = int'(num[4:0]);
      if (amt == 0) begin
        if (op[2:1] == 2'b01 || op[2:1] == 2'b10) amt = 32;
        else if (op[2:1] == 2'b11) return {d[0], cin, d[31:1]};
      end
    end
    for (int i = 0; i < amt; i++) begin
      case (op[2:1])
        2'b00:   begin c = v[31]; v = v << 1;            end
        2'b01:   begin c = v[0];  v = v >> 1;            end
        2'b10:   begin c = v[0];  v = {v[31], v[31:1]};  end
        default: begin c = v[0];  v = {v[0], v[31:1]};   end
      endcase
    end
    return {c, v};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [7:0] num,
                       input logic cin);
    sif.SHIFT_OP   = op;
    sif.Shift_Data = d;
    sif.Shift_Num  = num;
    sif.Carry_flag = cin;
    #2;
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] d,
                          input logic [7:0] num, input logic cin,
                          input logic [31:0] eout, input logic ec);
    drive(op, d, num, cin);
    check({tag, "_out"}, sif.Shift_Out, eout);
    check({tag, "_c"}, {31'd0, sif.Shift_Carry_Out}, {31'd0, ec});
  endtask

  initial begin
    logic [32:0] exp;
    logic [2:0]  op;
    logic [31:0] d;
    logic [7:0]  num;
    logic        cin;

    rst = 1'b1;
    drive(3'b000, 32'h0, 8'd0, 1'b0);
    #10;
    rst = 1'b0;
    @(negedge clk);

    directed("lsl_r3",   3'b001, 32'h3AC50001, 8'd3,  1'b0, 32'hD6280008, 1'b1);
    directed("lsl_i35",  3'b000, 32'h87654321, 8'd35, 1'b0, 32'h3B2A1908, 1'b0);
    directed("lsl_i0",   3'b000, 32'h773D8F5C, 8'd0,  1'b0, 32'h773D8F5C, 1'b0);
    directed("lsr_i0",   3'b010, 32'hF0000000, 8'd0,  1'b0, 32'h00000000, 1'b1);
    directed("lsr_i12",  3'b010, 32'h5F5555F5, 8'd12, 1'b0, 32'h0005F555, 1'b0);
    directed("lsr_r31",  3'b011, 32'hFFFFFFFF, 8'd31, 1'b0, 32'h00000001, 1'b1);
    directed("lsr_r33",  3'b011, 32'hFFFFFFFF, 8'd33, 1'b1, 32'h00000000, 1'b0);
    directed("asr_i0",   3'b100, 32'h7A9D029D, 8'd0,  1'b1, 32'h00000000, 1'b0);
    directed("asr_i6",   3'b100, 32'h8A9D029D, 8'd6,  1'b0, 32'hFE2A740A, 1'b0);
    directed("asr_r40",  3'b101, 32'h8A9D029D, 8'd40, 1'b1, 32'hFFFFFFFF, 1'b1);
    directed("rrx",      3'b110, 32'h999FF999, 8'd0,  1'b1, 32'hCCCFFCCC, 1'b1);
    directed("ror_i1",   3'b110, 32'h3F3F3F3F, 8'd1,  1'b0, 32'h9F9F9F9F, 1'b1);
    directed("ror_r39",  3'b111, 32'h1F2F3F4F, 8'd39, 1'b0, 32'h9E3E5E7E, 1'b1);
    directed("pt_lsl",   3'b001, 32'h12345678, 8'd0,  1'b1, 32'h12345678, 1'b1);
    directed("pt_lsr",   3'b011, 32'h12345678, 8'd0,  1'b1, 32'h12345678, 1'b1);
    directed("pt_asr",   3'b101, 32'h12345678, 8'd0,  1'b1, 32'h12345678, 1'b1);
    directed("pt_ror",   3'b111, 32'h12345678, 8'd0,  1'b0, 32'h12345678, 1'b0);
    directed("lsl_r32",  3'b001, 32'h00000001, 8'd32, 1'b0, 32'h00000000, 1'b1);
    directed("lsl_r33",  3'b001, 32'hFFFFFFFF, 8'd33, 1'b1, 32'h00000000, 1'b0);
    directed("lsr_r32",  3'b011, 32'h80000000, 8'd32, 1'b0, 32'h00000000, 1'b1);
    directed("ror_r32",  3'b111, 32'h80000001, 8'd32, 1'b0, 32'h80000001, 1'b1);
    directed("asr_r255", 3'b101, 32'h7FFFFFFF, 8'd255, 1'b1, 32'h00000000, 1'b0);

    for (int i = 0; i < 400; i++) begin
      op  = 3'($urandom_range(0, 7));
      d   = $urandom;
      cin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       num = 8'($urandom_range(0, 40));
        1:       num = 8'($urandom_range(28, 36));
        2:       num = (i % 2 == 0) ? 8'd0 : 8'd32;
        default: num = 8'($urandom);
      endcase
      exp = ref_model(op, d, num, cin);
      drive(op, d, num, cin);
      check($sformatf("rnd%0d_op%b_n%0d_out", i, op, num), sif.Shift_Out, exp[31:0]);
      check($sformatf("rnd%0d_op%b_n%0d_c", i, op, num), {31'd0, sif.Shift_Carry_Out},
            {31'd0, exp[32]});
    end

    op = 3'b100; d = 32'hC0FFEE11; num = 8'd9; cin = 1'b1;
    exp = ref_model(op, d, num, cin);
    drive(op, d, num, cin);
    rst = 1'b1;
    #13;
    check("rst_hi_out", sif.Shift_Out, exp[31:0]);
    check("rst_hi_c", {31'd0, sif.Shift_Carry_Out}, {31'd0, exp[32]});
    rst = 1'b0;
    #17;
    check("rst_lo_out", sif.Shift_Out, exp[31:0]);
    check("rst_lo_c", {31'd0, sif.Shift_Carry_Out}, {31'd0, exp[32]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
